// File: rtl/bo_pkg.sv
// rtl/bo_pkg.sv - shared state encoding, select constants and control word for bo_controle
package bo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LDX  = 3'd1,
    ST_S1   = 3'd2,
    ST_S2   = 3'd3,
    ST_S3   = 3'd4,
    ST_S4   = 3'd5,
    ST_S5   = 3'd6,
    ST_DONE = 3'd7
  } bo_state_e;

  // mux0: constant source
  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_Z = 2'b11;

  // mux1: operand v2
  localparam logic [1:0] SEL1_LX = 2'b00;
  localparam logic [1:0] SEL1_LS = 2'b01;
  localparam logic [1:0] SEL1_LH = 2'b10;
  localparam logic [1:0] SEL1_M0 = 2'b11;

  // mux2: operand v1
  localparam logic [1:0] SEL2_M0 = 2'b00;
  localparam logic [1:0] SEL2_LS = 2'b01;
  localparam logic [1:0] SEL2_LH = 2'b10;
  localparam logic [1:0] SEL2_LX = 2'b11;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef struct packed {
    logic       ld_x;
    logic       ld_s;
    logic       ld_h;
    logic [1:0] sel_m0;
    logic [1:0] sel_m1;
    logic [1:0] sel_m2;
    logic       op_mul;
  } bo_ctrl_t;

endpackage

// File: rtl/bo_controle_decode.sv
// rtl/bo_controle_decode.sv - combinational state to control-word decoder for the BO datapath
module bo_controle_decode
  import bo_pkg::*;
(
  input  logic [2:0] state,
  output bo_ctrl_t   ctrl
);

  // Fields not used by a state stay at 00 so the datapath never sees X
  always_comb begin
    ctrl = '0;
    case (state)
      ST_LDX: ctrl.ld_x = 1'b1;
      ST_S1: begin
        ctrl.sel_m0 = SEL_A;
        ctrl.sel_m1 = SEL1_LX;
        ctrl.sel_m2 = SEL2_M0;
        ctrl.op_mul = OP_MUL;
        ctrl.ld_s   = 1'b1;
      end
      ST_S2: begin
        ctrl.sel_m1 = SEL1_LX;
        ctrl.sel_m2 = SEL2_LS;
        ctrl.op_mul = OP_MUL;
        ctrl.ld_s   = 1'b1;
      end
      ST_S3: begin
        ctrl.sel_m0 = SEL_B;
        ctrl.sel_m1 = SEL1_LX;
        ctrl.sel_m2 = SEL2_M0;
        ctrl.op_mul = OP_MUL;
        ctrl.ld_h   = 1'b1;
      end
      ST_S4: begin
        ctrl.sel_m1 = SEL1_LH;
        ctrl.sel_m2 = SEL2_LS;
        ctrl.op_mul = OP_ADD;
        ctrl.ld_s   = 1'b1;
      end
      ST_S5: begin
        ctrl.sel_m0 = SEL_C;
        ctrl.sel_m1 = SEL1_M0;
        ctrl.sel_m2 = SEL2_LS;
        ctrl.op_mul = OP_ADD;
        ctrl.ld_s   = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/bo_controle.sv
// rtl/bo_controle.sv - Moore sequencer for Y = A*X^2 + B*X + C; BO_CONTROLE_STEP_EN adds a step input
module bo_controle
  import bo_pkg::*;
#(
  parameter bit DONE_HOLD = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
`ifdef BO_CONTROLE_STEP_EN
  input  logic       step,
`endif
  output logic       ld_x,
  output logic       ld_s,
  output logic       ld_h,
  output logic [1:0] sel_m0,
  output logic [1:0] sel_m1,
  output logic [1:0] sel_m2,
  output logic       op_mul,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_o
);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       advance;
  bo_ctrl_t   ctrl;

`ifdef BO_CONTROLE_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LDX;
      ST_LDX:  if (advance) state_nxt = ST_S1;
      ST_S1:   if (advance) state_nxt = ST_S2;
      ST_S2:   if (advance) state_nxt = ST_S3;
      ST_S3:   if (advance) state_nxt = ST_S4;
      ST_S4:   if (advance) state_nxt = ST_S5;
      ST_S5:   if (advance) state_nxt = ST_DONE;
      ST_DONE: if (!DONE_HOLD || !start) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  bo_controle_decode u_decode (
    .state (state),
    .ctrl  (ctrl)
  );

  // A held step must not reload any register; selects stay visible for inspection
  assign ld_x    = ctrl.ld_x & advance;
  assign ld_s    = ctrl.ld_s & advance;
  assign ld_h    = ctrl.ld_h & advance;
  assign sel_m0  = ctrl.sel_m0;
  assign sel_m1  = ctrl.sel_m1;
  assign sel_m2  = ctrl.sel_m2;
  assign op_mul  = ctrl.op_mul;
  assign busy    = (state != ST_IDLE) && (state != ST_DONE);
  assign done    = (state == ST_DONE);
  assign state_o = state;

endmodule

// File: tb/tb_bo_controle.sv
// tb/tb_bo_controle.sv - scoreboard bench for bo_controle with a BO datapath model (A=5, B=2, C=9)
module tb_bo_controle;

  typedef struct {
    logic [9:0] cw;
    logic [2:0] st;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start0 = 1'b0;
  logic step = 1'b1;
  logic [15:0] x = 16'd0;

  logic ld_x, ld_s, ld_h, op_mul, busy, done;
  logic [1:0] sel_m0, sel_m1, sel_m2;
  logic [2:0] state_o;
  logic ld_x0, ld_s0, ld_h0, op_mul0, busy0, done0;
  logic [1:0] sel_m00, sel_m10, sel_m20;
  logic [2:0] state_o0;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  logic [15:0] y_q[$];

  always #5 clk = ~clk;

  bo_controle #(.DONE_HOLD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef BO_CONTROLE_STEP_EN
    .step(step),
`endif
    .ld_x(ld_x), .ld_s(ld_s), .ld_h(ld_h),
    .sel_m0(sel_m0), .sel_m1(sel_m1), .sel_m2(sel_m2), .op_mul(op_mul),
    .busy(busy), .done(done), .state_o(state_o)
  );

  bo_controle #(.DONE_HOLD(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
`ifdef BO_CONTROLE_STEP_EN
    .step(step),
`endif
    .ld_x(ld_x0), .ld_s(ld_s0), .ld_h(ld_h0),
    .sel_m0(sel_m00), .sel_m1(sel_m10), .sel_m2(sel_m20), .op_mul(op_mul0),
    .busy(busy0), .done(done0), .state_o(state_o0)
  );

  // BO datapath model driven by the controller outputs
  logic [15:0] lx, ls, lh, m0, v1, v2, res;
  always_comb begin
    case (sel_m0)
      2'b00: m0 = 16'd5;
      2'b01: m0 = 16'd2;
      2'b10: m0 = 16'd9;
      default: m0 = 16'd0;
    endcase
    case (sel_m1)
      2'b00: v2 = lx;
      2'b01: v2 = ls;
      2'b10: v2 = lh;
      default: v2 = m0;
    endcase
    case (sel_m2)
      2'b00: v1 = m0;
      2'b01: v1 = ls;
      2'b10: v1 = lh;
      default: v1 = lx;
    endcase
    res = op_mul ? v1 * v2 : v1 + v2;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lx <= '0; ls <= '0; lh <= '0;
    end else begin
      if (ld_x) lx <= x;
      if (ld_s) ls <= res;
      if (ld_h) lh <= res;
    end
  end

  wire [9:0] cw = {ld_x, ld_s, ld_h, sel_m0, sel_m1, sel_m2, op_mul};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [15:0] xv);
    exp_t e;
    logic [9:0] tbl [7];
    tbl[0] = {1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[1] = {1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1};
    tbl[2] = {1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 1'b1};
    tbl[3] = {1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 1'b1};
    tbl[4] = {1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0};
    tbl[5] = {1'b0, 1'b1, 1'b0, 2'b10, 2'b11, 2'b01, 1'b0};
    tbl[6] = 10'd0;
    for (int i = 0; i < 7; i++) begin
      e.cw = tbl[i];
      e.st = 3'(i + 1);
      e.busy = (i < 6);
      e.done = (i == 6);
      exp_q.push_back(e);
    end
    y_q.push_back(16'd5 * xv * xv + 16'd2 * xv + 16'd9);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_cw"}, {22'd0, cw}, {22'd0, e.cw});
      check({tag, "_state"}, {29'd0, state_o}, {29'd0, e.st});
      check({tag, "_busy_done"}, {30'd0, busy, done}, {30'd0, e.busy, e.done});
    end
  endtask

  task automatic check_result(input string tag);
    if (y_q.size() == 0) check({tag, "_yq_empty"}, 32'd1, 32'd0);
    else check({tag, "_ls"}, {16'd0, ls}, {16'd0, y_q.pop_front()});
  endtask

  // mode 0: start pulse, 1: start toggles while busy, 2: start held high
  task automatic run(input string tag, input logic [15:0] xv, input int mode);
    int busy_cnt = 0;
    x = xv;
    push_run(xv);
    start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      pop_check(tag);
      if (busy) busy_cnt++;
      if (mode == 0) start = 1'b0;
      else if (mode == 1) start = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    check_result(tag);
    check({tag, "_busy_cycles"}, busy_cnt, 6);
    if (mode == 2) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        check({tag, "_hold_done"}, {28'd0, done, state_o}, {28'd0, 1'b1, 3'd7});
      end
      start = 1'b0;
    end
    tick();
    check({tag, "_idle"}, {28'd0, done, state_o}, 32'd0);
    tick();
    check({tag, "_no_rerun"}, {29'd0, state_o}, 32'd0);
  endtask

  initial begin
    tick();
    check("reset_outputs", {14'd0, cw, busy, done, state_o}, 32'd0);
    check("reset_outputs_hold0", {14'd0, ld_x0, ld_s0, ld_h0, sel_m00, sel_m10, sel_m20, op_mul0, busy0, done0, state_o0}, 32'd0);
    rst_n = 1'b1;
    tick();

    run("x3", 16'd3, 0);
    run("x0", 16'd0, 0);
    run("x7", 16'd7, 0);
    run("x3_toggle", 16'd3, 1);
    run("x3_hold", 16'd3, 2);

    // DONE_HOLD=0 instance: one-cycle done then automatic rerun with start held
    start0 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("h0_state", {29'd0, state_o0}, i + 1);
    end
    check("h0_done", {31'd0, done0}, 32'd1);
    tick();
    check("h0_back_idle", {28'd0, done0, state_o0}, 32'd0);
    tick();
    check("h0_rerun", {29'd0, state_o0}, 32'd1);
    start0 = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("h0_end_idle", {29'd0, state_o0}, 32'd0);

    // asynchronous reset during S3
    x = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("rst_in_s3", {29'd0, state_o}, 32'd4);
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {14'd0, cw, busy, done, state_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_release_idle", {29'd0, state_o}, 32'd0);
    run("after_rst", 16'd3, 0);

`ifdef BO_CONTROLE_STEP_EN
    x = 16'd3;
    push_run(16'd3);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      pop_check("step_pre");
      start = 1'b0;
    end
    step = 1'b0;
    #1;
    check("step_hold_ld", {29'd0, ld_x, ld_s, ld_h}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("step_hold_state", {29'd0, state_o}, 32'd3);
      check("step_hold_ld", {29'd0, ld_x, ld_s, ld_h}, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      step = 1'b1;
      tick();
      pop_check("step_run");
      step = 1'b0;
      if (i < 3) begin
        tick();
        check("step_gap_ld", {29'd0, ld_x, ld_s, ld_h}, 32'd0);
      end
    end
    step = 1'b1;
    check_result("step_run");
    tick();
    check("step_idle", {29'd0, state_o}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
